multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Moore-style control FSM that sequences the shared single-ALU/single-memory RISC-V datapath over multiple cycles per instruction.
- Replaces the single-cycle control path when instruction and data memory are unified behind one port with a ready handshake.
- Decodes the instruction held in the datapath instruction register (IR).
- Drives all datapath enables and muxes, ALU_Control and ImmSrc.
- Flags unsupported opcodes.

Parameters:
- RESET_STATE, 4'd0, state code entered on reset (FETCH). Do not change.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- Instr  input  32  IR contents; valid from DECODE onward
- Zero  input  1  ALU zero flag
- mem_ready  input  1  unified memory completes current access this cycle
- PCWrite  output  1  PC register enable
- IRWrite  output  1  IR and OldPC enable
- AdrSrc  output  1  memory address mux: 0=PC, 1=ALUOut
- MemWrite  output  1  memory write strobe
- RegWrite  output  1  register file write enable
- ALUSrcA  output  2  00=PC, 01=OldPC, 10=rs1 (A reg)
- ALUSrcB  output  2  00=rs2 (B reg), 01=ImmExt, 10=constant 4
- ResultSrc  output  2  00=ALUOut, 01=memory data reg, 10=ALU result direct
- ImmSrc  output  2  00=I, 01=S, 10=B, 11=J
- ALU_Control  output  4  0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT
- illegal_instr  output  1  high while in TRAP
- state_dbg  output  4  current state code

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset: state goes to FETCH. While rst_n=0, PCWrite, IRWrite, MemWrite and RegWrite are forced to 0 and illegal_instr is 0. Other outputs take FETCH values.
- Reset mid-instruction: the instruction is aborted, no further write enables are asserted, and fetch restarts after release.
- Supported opcodes: lw 0000011, sw 0100011, R-type 0110011, I-ALU 0010011, beq 1100011, jal 1101111. Any other opcode is illegal.
- ImmSrc: combinational from Instr[6:0] in all states. sw→01, beq→10, jal→11, otherwise 00.
- ALUOp (internal) to ALU_Control:
  - ALUOp 00 → ADD.
  - ALUOp 01 → SUB.
  - ALUOp 10 → decode funct3 = Instr[14:12]:
    - 000: SUB if Instr[5] & Instr[30], else ADD.
    - 010: SLT.
    - 100: XOR.
    - 110: OR.
    - 111: AND.
    - Any other funct3: ADD.
- States, codes, outputs and transitions (unlisted outputs are 0):
  - FETCH(0): AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite=PCWrite=mem_ready. Stay while mem_ready=0; go to DECODE when mem_ready=1.
  - DECODE(1): ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target into ALUOut).
    - lw/sw→MEMADR(2).
    - R→EXECUTER(6).
    - I-ALU→EXECUTEI(8).
    - beq→BEQ(10).
    - jal→JAL(9).
    - Otherwise→TRAP(11).
  - MEMADR(2): ALUSrcA=10, ALUSrcB=01, ALUOp=00. lw→MEMREAD(3), sw→MEMWRITE(5).
  - MEMREAD(3): AdrSrc=1, ResultSrc=00. Stay until mem_ready=1, then MEMWB(4).
  - MEMWB(4): ResultSrc=01, RegWrite=1. Next FETCH.
  - MEMWRITE(5): AdrSrc=1, ResultSrc=00, MemWrite=1. MemWrite is held until mem_ready=1, then FETCH.
  - EXECUTER(6): ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next ALUWB(7).
  - EXECUTEI(8): ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next ALUWB(7).
  - ALUWB(7): ResultSrc=00, RegWrite=1. Next FETCH.
  - JAL(9): ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1. Next ALUWB.
  - BEQ(10): ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, PCWrite=Zero. Next FETCH.
  - TRAP(11): illegal_instr=1, all enables 0. Stays in TRAP until reset.
- Unused state codes: go to FETCH on the next edge.
- Latency in cycles, assuming mem_ready=1 on first request: lw 5, sw 4, R/I 4, jal 4, beq 3. Each mem_ready=0 cycle adds one cycle.

Test Plan:
- Reset held, then released with mem_ready=1 → state_dbg=0 during reset with all write enables 0. First post-reset cycle: IRWrite=PCWrite=1. state_dbg sequence 0→1.
- Instr=0x00A12023 (sw), mem_ready low for 2 cycles in MEMWRITE → states 0,1,2,5,5,5,0. MemWrite high for 3 cycles with AdrSrc=1.
- Instr=0x40B50533 (sub) → state sequence 0,1,6,7. ALU_Control=0001 in EXECUTER. RegWrite=1 only in ALUWB.
- beq with Zero=1, then Zero=0 → PCWrite=1 in BEQ in the first case, 0 in the second. ALU_Control=0001 in both. Returns to FETCH after 3 cycles.
- jal 0x008000EF → state sequence 0,1,9,7. ImmSrc=11. PCWrite=1 in JAL. RegWrite=1 in ALUWB.
- Instr=0x0000007F → TRAP: illegal_instr=1 persists for 10 cycles with no enables asserted. Asserting rst_n=0 → FETCH.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and the shared RISC-V datapath.
// The master side is the controller: it reads IR/flags/memory status and drives the datapath controls.
interface multicycle_controller_if;
   logic [31:0] Instr;
   logic        Zero;
   logic        mem_ready;
   logic        PCWrite;
   logic        IRWrite;
   logic        AdrSrc;
   logic        MemWrite;
   logic        RegWrite;
   logic [1:0]  ALUSrcA;
   logic [1:0]  ALUSrcB;
   logic [1:0]  ResultSrc;
   logic [1:0]  ImmSrc;
   logic [3:0]  ALU_Control;
   logic        illegal_instr;
   logic [3:0]  state_dbg;

   modport master (
      input  Instr, Zero, mem_ready,
      output PCWrite, IRWrite, AdrSrc, MemWrite, RegWrite,
             ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALU_Control,
             illegal_instr, state_dbg
   );

   modport slave (
      output Instr, Zero, mem_ready,
      input  PCWrite, IRWrite, AdrSrc, MemWrite, RegWrite,
             ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALU_Control,
             illegal_instr, state_dbg
   );
endinterface

// File: rtl/multicycle_controller.sv
// Moore control FSM for the single-ALU / unified-memory RISC-V datapath.
// Write enables are gated by rst_n so nothing commits while reset is held.
module multicycle_controller #(
   parameter logic [3:0] RESET_STATE = 4'd0
) (
   input  logic                           clk,
   input  logic                           rst_n,
   multicycle_controller_if.master        bus
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_ALUWB    = 4'd7,
      S_EXECUTEI = 4'd8,
      S_JAL      = 4'd9,
      S_BEQ      = 4'd10,
      S_TRAP     = 4'd11
   } state_t;

   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_AND = 4'b0010;
   localparam logic [3:0] ALU_OR  = 4'b0011;
   localparam logic [3:0] ALU_XOR = 4'b0100;
   localparam logic [3:0] ALU_SLT = 4'b0101;

   state_t      state_q, state_d;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [1:0]  alu_op;
   logic        pc_we, ir_we, mem_we, reg_we;
   logic        adr_src, illegal;
   logic [1:0]  src_a, src_b, res_src;
   logic [3:0]  alu_ctrl;
   logic [1:0]  imm_src;

   assign opcode = bus.Instr[6:0];
   assign funct3 = bus.Instr[14:12];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= state_t'(RESET_STATE);
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      pc_we   = 1'b0;
      ir_we   = 1'b0;
      mem_we  = 1'b0;
      reg_we  = 1'b0;
      adr_src = 1'b0;
      illegal = 1'b0;
      src_a   = 2'b00;
      src_b   = 2'b00;
      res_src = 2'b00;
      alu_op  = 2'b00;
      case (state_q)
         S_FETCH: begin
            src_b   = 2'b10;
            res_src = 2'b10;
            ir_we   = bus.mem_ready;
            pc_we   = bus.mem_ready;
            if (bus.mem_ready) state_d = S_DECODE;
         end
         S_DECODE: begin
            // Branch target is precomputed here from OldPC + imm into ALUOut
            src_a = 2'b01;
            src_b = 2'b01;
            case (opcode)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_R:         state_d = S_EXECUTER;
               OP_I:         state_d = S_EXECUTEI;
               OP_BEQ:       state_d = S_BEQ;
               OP_JAL:       state_d = S_JAL;
               default:      state_d = S_TRAP;
            endcase
         end
         S_MEMADR: begin
            src_a   = 2'b10;
            src_b   = 2'b01;
            state_d = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            adr_src = 1'b1;
            if (bus.mem_ready) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            res_src = 2'b01;
            reg_we  = 1'b1;
            state_d = S_FETCH;
         end
         S_MEMWRITE: begin
            adr_src = 1'b1;
            mem_we  = 1'b1;
            if (bus.mem_ready) state_d = S_FETCH;
         end
         S_EXECUTER: begin
            src_a   = 2'b10;
            alu_op  = 2'b10;
            state_d = S_ALUWB;
         end
         S_EXECUTEI: begin
            src_a   = 2'b10;
            src_b   = 2'b01;
            alu_op  = 2'b10;
            state_d = S_ALUWB;
         end
         S_ALUWB: begin
            reg_we  = 1'b1;
            state_d = S_FETCH;
         end
         S_JAL: begin
            src_a   = 2'b01;
            src_b   = 2'b10;
            pc_we   = 1'b1;
            state_d = S_ALUWB;
         end
         S_BEQ: begin
            src_a   = 2'b10;
            alu_op  = 2'b01;
            pc_we   = bus.Zero;
            state_d = S_FETCH;
         end
         S_TRAP: illegal = 1'b1;
         default: state_d = S_FETCH;
      endcase
   end

   always_comb begin
      alu_ctrl = ALU_ADD;
      case (alu_op)
         2'b01: alu_ctrl = ALU_SUB;
         2'b10: begin
            case (funct3)
               3'b000:  alu_ctrl = (bus.Instr[5] & bus.Instr[30]) ? ALU_SUB : ALU_ADD;
               3'b010:  alu_ctrl = ALU_SLT;
               3'b100:  alu_ctrl = ALU_XOR;
               3'b110:  alu_ctrl = ALU_OR;
               3'b111:  alu_ctrl = ALU_AND;
               default: alu_ctrl = ALU_ADD;
            endcase
         end
         default: alu_ctrl = ALU_ADD;
      endcase
   end

   always_comb begin
      case (opcode)
         OP_SW:   imm_src = 2'b01;
         OP_BEQ:  imm_src = 2'b10;
         OP_JAL:  imm_src = 2'b11;
         default: imm_src = 2'b00;
      endcase
   end

   assign bus.PCWrite       = pc_we  & rst_n;
   assign bus.IRWrite       = ir_we  & rst_n;
   assign bus.MemWrite      = mem_we & rst_n;
   assign bus.RegWrite      = reg_we & rst_n;
   assign bus.AdrSrc        = adr_src;
   assign bus.ALUSrcA       = src_a;
   assign bus.ALUSrcB       = src_b;
   assign bus.ResultSrc     = res_src;
   assign bus.ImmSrc        = imm_src;
   assign bus.ALU_Control   = alu_ctrl;
   assign bus.illegal_instr = illegal & rst_n;
   assign bus.state_dbg     = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: state sequences, enables and ALU decode per instruction class.
module tb_multicycle_controller;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;

   multicycle_controller_if bus();

   multicycle_controller #(.RESET_STATE(4'd0)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Leaves the bench at a negedge with reset just released, DUT in FETCH.
   task automatic do_reset();
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      bus.Instr = 32'h0000_0013;
      bus.Zero = 1'b0;
      bus.mem_ready = 1'b1;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (bus.state_dbg !== 4'd0) begin
         errors++; $display("FAIL reset_state: got %0d expected 0", bus.state_dbg);
      end
      checks++;
      if ({bus.PCWrite, bus.IRWrite, bus.MemWrite, bus.RegWrite, bus.illegal_instr} !== 5'b0) begin
         errors++; $display("FAIL reset_enables: got %b expected 00000",
            {bus.PCWrite, bus.IRWrite, bus.MemWrite, bus.RegWrite, bus.illegal_instr});
      end
      rst_n = 1'b1;
      #1;
      checks++;
      if ({bus.IRWrite, bus.PCWrite} !== 2'b11) begin
         errors++; $display("FAIL post_reset_fetch_we: got %b expected 11", {bus.IRWrite, bus.PCWrite});
      end
      checks++;
      if ({bus.ALUSrcB, bus.ResultSrc, bus.AdrSrc} !== 5'b10100) begin
         errors++; $display("FAIL fetch_muxes: got %b expected 10100", {bus.ALUSrcB, bus.ResultSrc, bus.AdrSrc});
      end
      next_cycle();
      checks++;
      if (bus.state_dbg !== 4'd1) begin
         errors++; $display("FAIL reset_to_decode: got %0d expected 1", bus.state_dbg);
      end
   endtask

   task automatic test_sw_stall();
      logic [3:0] st [7];
      logic       mr [7];
      int         mw_cnt = 0;
      st = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd5, 4'd0};
      mr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      bus.Instr = 32'h00A1_2023;
      bus.mem_ready = 1'b1;
      do_reset();
      for (int i = 0; i < 7; i++) begin
         bus.mem_ready = mr[i];
         #1;
         checks++;
         if (bus.state_dbg !== st[i]) begin
            errors++; $display("FAIL sw_state[%0d]: got %0d expected %0d", i, bus.state_dbg, st[i]);
         end
         if (bus.MemWrite === 1'b1) mw_cnt++;
         if (st[i] == 4'd5) begin
            checks++;
            if ({bus.MemWrite, bus.AdrSrc} !== 2'b11) begin
               errors++; $display("FAIL sw_memwrite[%0d]: got %b expected 11", i, {bus.MemWrite, bus.AdrSrc});
            end
         end
         if (i == 1) begin
            checks++;
            if (bus.ImmSrc !== 2'b01) begin
               errors++; $display("FAIL sw_immsrc: got %b expected 01", bus.ImmSrc);
            end
         end
         next_cycle();
      end
      checks++;
      if (mw_cnt != 3) begin
         errors++; $display("FAIL sw_memwrite_cycles: got %0d expected 3", mw_cnt);
      end
   endtask

   task automatic test_lw_stall();
      logic [3:0] st [8];
      logic       mr [8];
      st = '{4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd4, 4'd0};
      mr = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      bus.Instr = 32'h0005_2583;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         bus.mem_ready = mr[i];
         #1;
         checks++;
         if (bus.state_dbg !== st[i]) begin
            errors++; $display("FAIL lw_state[%0d]: got %0d expected %0d", i, bus.state_dbg, st[i]);
         end
         if (i == 0) begin
            checks++;
            if ({bus.IRWrite, bus.PCWrite} !== 2'b00) begin
               errors++; $display("FAIL lw_fetch_stall_we: got %b expected 00", {bus.IRWrite, bus.PCWrite});
            end
         end
         checks++;
         if (bus.RegWrite !== (st[i] == 4'd4)) begin
            errors++; $display("FAIL lw_regwrite[%0d]: got %b expected %b", i, bus.RegWrite, st[i] == 4'd4);
         end
         if (st[i] == 4'd4) begin
            checks++;
            if (bus.ResultSrc !== 2'b01) begin
               errors++; $display("FAIL lw_wb_result: got %b expected 01", bus.ResultSrc);
            end
         end
         next_cycle();
      end
   endtask

   task automatic test_sub();
      logic [3:0] st [5];
      st = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
      bus.Instr = 32'h40B5_0533;
      bus.mem_ready = 1'b1;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++;
         if (bus.state_dbg !== st[i]) begin
            errors++; $display("FAIL sub_state[%0d]: got %0d expected %0d", i, bus.state_dbg, st[i]);
         end
         checks++;
         if (bus.RegWrite !== (st[i] == 4'd7)) begin
            errors++; $display("FAIL sub_regwrite[%0d]: got %b expected %b", i, bus.RegWrite, st[i] == 4'd7);
         end
         if (st[i] == 4'd6) begin
            checks++;
            if ({bus.ALU_Control, bus.ALUSrcA, bus.ALUSrcB} !== 8'b0001_10_00) begin
               errors++; $display("FAIL sub_exec: got %b expected 00011000",
                  {bus.ALU_Control, bus.ALUSrcA, bus.ALUSrcB});
            end
         end
         next_cycle();
      end
   endtask

   task automatic test_ialu();
      // xori -> XOR; addi with imm bit 30 set must stay ADD since Instr[5]=0
      logic [31:0] ins [3];
      logic [3:0]  exp_alu [3];
      ins     = '{32'h0FF5_4513, 32'h4005_0513, 32'h0015_2513};
      exp_alu = '{4'b0100, 4'b0000, 4'b0101};
      bus.mem_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         bus.Instr = ins[k];
         do_reset();
         next_cycle();
         next_cycle();
         #1;
         checks++;
         if (bus.state_dbg !== 4'd8 || bus.ALU_Control !== exp_alu[k] || bus.ALUSrcB !== 2'b01) begin
            errors++; $display("FAIL ialu[%0d]: got state %0d alu %b srcb %b expected state 8 alu %b srcb 01",
               k, bus.state_dbg, bus.ALU_Control, bus.ALUSrcB, exp_alu[k]);
         end
      end
   endtask

   task automatic test_beq();
      for (int z = 1; z >= 0; z--) begin
         bus.Instr = 32'h00B5_0463;
         bus.Zero = z[0];
         bus.mem_ready = 1'b1;
         do_reset();
         next_cycle();
         next_cycle();
         #1;
         checks++;
         if (bus.state_dbg !== 4'd10 || bus.PCWrite !== z[0] || bus.ALU_Control !== 4'b0001) begin
            errors++; $display("FAIL beq_z%0d: got state %0d pcw %b alu %b expected state 10 pcw %b alu 0001",
               z, bus.state_dbg, bus.PCWrite, bus.ALU_Control, z[0]);
         end
         checks++;
         if (bus.ImmSrc !== 2'b10) begin
            errors++; $display("FAIL beq_immsrc: got %b expected 10", bus.ImmSrc);
         end
         next_cycle();
         checks++;
         if (bus.state_dbg !== 4'd0) begin
            errors++; $display("FAIL beq_return_z%0d: got %0d expected 0", z, bus.state_dbg);
         end
      end
      bus.Zero = 1'b0;
   endtask

   task automatic test_jal();
      logic [3:0] st [5];
      st = '{4'd0, 4'd1, 4'd9, 4'd7, 4'd0};
      bus.Instr = 32'h0080_00EF;
      bus.mem_ready = 1'b1;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++;
         if (bus.state_dbg !== st[i] || bus.ImmSrc !== 2'b11) begin
            errors++; $display("FAIL jal_state[%0d]: got %0d imm %b expected %0d imm 11",
               i, bus.state_dbg, bus.ImmSrc, st[i]);
         end
         if (st[i] == 4'd9) begin
            checks++;
            if ({bus.PCWrite, bus.RegWrite} !== 2'b10) begin
               errors++; $display("FAIL jal_pcwrite: got %b expected 10", {bus.PCWrite, bus.RegWrite});
            end
         end
         if (st[i] == 4'd7) begin
            checks++;
            if ({bus.PCWrite, bus.RegWrite} !== 2'b01) begin
               errors++; $display("FAIL jal_regwrite: got %b expected 01", {bus.PCWrite, bus.RegWrite});
            end
         end
         next_cycle();
      end
   endtask

   task automatic test_reset_mid();
      bus.Instr = 32'h40B5_0533;
      bus.mem_ready = 1'b1;
      do_reset();
      next_cycle();
      next_cycle();
      next_cycle();
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.state_dbg !== 4'd0 || {bus.PCWrite, bus.IRWrite, bus.MemWrite, bus.RegWrite} !== 4'b0) begin
         errors++; $display("FAIL reset_mid: got state %0d we %b expected state 0 we 0000",
            bus.state_dbg, {bus.PCWrite, bus.IRWrite, bus.MemWrite, bus.RegWrite});
      end
      next_cycle();
      rst_n = 1'b1;
      #1;
      checks++;
      if (bus.state_dbg !== 4'd0 || {bus.IRWrite, bus.PCWrite} !== 2'b11) begin
         errors++; $display("FAIL reset_mid_restart: got state %0d we %b expected state 0 we 11",
            bus.state_dbg, {bus.IRWrite, bus.PCWrite});
      end
   endtask

   task automatic test_trap();
      bus.Instr = 32'h0000_007F;
      bus.mem_ready = 1'b1;
      do_reset();
      next_cycle();
      next_cycle();
      for (int i = 0; i < 10; i++) begin
         #1;
         checks++;
         if (bus.state_dbg !== 4'd11 || bus.illegal_instr !== 1'b1 ||
             {bus.PCWrite, bus.IRWrite, bus.MemWrite, bus.RegWrite} !== 4'b0) begin
            errors++; $display("FAIL trap[%0d]: got state %0d ill %b we %b expected state 11 ill 1 we 0000",
               i, bus.state_dbg, bus.illegal_instr, {bus.PCWrite, bus.IRWrite, bus.MemWrite, bus.RegWrite});
         end
         next_cycle();
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.state_dbg !== 4'd0 || bus.illegal_instr !== 1'b0) begin
         errors++; $display("FAIL trap_reset: got state %0d ill %b expected state 0 ill 0",
            bus.state_dbg, bus.illegal_instr);
      end
      next_cycle();
      rst_n = 1'b1;
   endtask

   initial begin
      bus.Instr = 32'h0;
      bus.Zero = 1'b0;
      bus.mem_ready = 1'b0;
      test_reset();
      test_sw_stall();
      test_lw_stall();
      test_sub();
      test_ialu();
      test_beq();
      test_jal();
      test_reset_mid();
      test_trap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
